// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: hazard sequencer state encoding and register-file constants
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: W-bit up counter, inc_i adds one, holds at all-ones, rst_i clears (sync, active-high)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  always_ff @(posedge clk_i) cnt_o <= rst_i ? '0 : (inc_i & ~&cnt_o) ? cnt_o + 1'b1 : cnt_o;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use bubble, branch flush, dmem-wait freeze with timeout halt, stall/flush perf counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int WAIT_W      = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IF_ID_RSaddr_i,
  input  logic [4:0]       IF_ID_RTaddr_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RTaddr_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             PC_write_o,
  output logic             IF_ID_write_o,
  output logic             ID_EX_bubble_o,
  output logic             IF_ID_flush_o,
  output logic             pipe_stall_o,
  output logic             error_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  state_t state, state_n;
  logic [WAIT_W-1:0] wcnt, wcnt_n;
  logic err_n, memstall, loaduse, timeout, active, frozen;
  assign memstall = dmem_req_i & ~dmem_ack_i;
  assign loaduse = ID_EX_MemRead_i & (ID_EX_RTaddr_i != REG_ZERO) &
                   (ID_EX_RTaddr_i == IF_ID_RSaddr_i | ID_EX_RTaddr_i == IF_ID_RTaddr_i);
  assign timeout = wcnt == WAIT_W'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk_i) begin
    state   <= rst_i ? RUN : state_n;
    wcnt    <= rst_i ? '0 : wcnt_n;
    error_o <= rst_i ? 1'b0 : err_n;
  end
  always_comb begin
    state_n = state == RUN ? (memstall ? MEM_WAIT : RUN) :
              state == MEM_WAIT ? (dmem_ack_i ? RUN : timeout ? HALT : MEM_WAIT) : HALT;
    wcnt_n = state == RUN ? WAIT_W'(memstall) :
             state == MEM_WAIT ? (dmem_ack_i ? '0 : timeout ? wcnt : wcnt + 1'b1) : wcnt;
    err_n = error_o | (state == MEM_WAIT & ~dmem_ack_i & timeout);
  end
  // The ack cycle of MEM_WAIT behaves like RUN, so load-use and branch rules apply there too.
  always_comb begin
    active = ~rst_i & (state == RUN | state == MEM_WAIT & dmem_ack_i);
    frozen = ~rst_i & (state == HALT | state == MEM_WAIT & ~dmem_ack_i | state == RUN & memstall);
    ID_EX_bubble_o = active & ~memstall & loaduse;
    IF_ID_flush_o = active & ~memstall & ~loaduse & branch_taken_i;
    pipe_stall_o = frozen;
    PC_write_o = ~frozen & ~ID_EX_bubble_o;
    IF_ID_write_o = PC_write_o;
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(~PC_write_o), .cnt_o(stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(IF_ID_flush_o), .cnt_o(flush_cnt_o)
  );
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline, sitting beside the forwarding logic in the ID/EX region.
- Detects load-use hazards (the one case forwarding cannot cover) and inserts a single bubble.
- Flushes IF/ID on a taken branch.
- Freezes the whole pipeline while a data-memory access awaits acknowledge, with a timeout that halts the core.
- Keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before entering HALT (legal range 2..2^WAIT_W-1).
WAIT_W, 8, width of the internal wait counter.
CNT_W, 16, width of the perf counters.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous reset, active-high.
IF_ID_RSaddr_i  in  5  rs of the instruction in ID.
IF_ID_RTaddr_i  in  5  rt of the instruction in ID.
ID_EX_MemRead_i  in  1  instruction in EX is a load.
ID_EX_RTaddr_i  in  5  load destination in EX.
branch_taken_i  in  1  branch in ID resolved taken.
dmem_req_i  in  1  MEM stage is issuing a load/store this cycle.
dmem_ack_i  in  1  data memory completes the access this cycle.
PC_write_o  out  1  1 = PC may update.
IF_ID_write_o  out  1  1 = IF/ID may update.
ID_EX_bubble_o  out  1  1 = zero the control bits entering ID/EX.
IF_ID_flush_o  out  1  1 = load a NOP into IF/ID.
pipe_stall_o  out  1  1 = hold ID/EX, EX/MEM, MEM/WB.
error_o  out  1  sticky memory-timeout flag.
stall_cnt_o  out  CNT_W  cycles with PC_write_o=0.
flush_cnt_o  out  CNT_W  cycles with IF_ID_flush_o=1.

Behaviour:
- State machine has three states: RUN, MEM_WAIT, HALT. Reset places it in RUN, clears the wait counter, stall_cnt_o, flush_cnt_o and error_o.
- Control outputs are combinational from state and inputs, and take effect in the same cycle.
- While rst_i=1, control outputs are held at their idle values: PC_write_o=1, IF_ID_write_o=1, all others 0.
- Definitions used below:
  - memstall = dmem_req_i & ~dmem_ack_i
  - loaduse = ID_EX_MemRead_i & (ID_EX_RTaddr_i != 0) & (ID_EX_RTaddr_i == IF_ID_RSaddr_i | ID_EX_RTaddr_i == IF_ID_RTaddr_i)
- RUN priority, highest first:
  - memstall: pipe_stall_o=1, PC_write_o=0, IF_ID_write_o=0, bubble=0, flush=0. Next state MEM_WAIT, wait counter set to 1.
  - loaduse: PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1. Flush is suppressed even if branch_taken_i=1; the branch is re-evaluated next cycle. Stay in RUN.
  - branch_taken_i: IF_ID_flush_o=1, PC_write_o=1.
  - otherwise: idle values.
- A request acknowledged in the same cycle (req & ack) is a hit: no stall, stay in RUN.
- MEM_WAIT:
  - Outputs: pipe_stall_o=1, PC_write_o=0, IF_ID_write_o=0, bubble=0, flush=0. loaduse and branch_taken_i are ignored.
  - If dmem_ack_i=1: pipe_stall_o=0 and PC/IF_ID writes are re-enabled in that cycle. The loaduse and branch rules of RUN apply in the ack cycle. Next state RUN, wait counter cleared.
  - Else if wait counter == MEM_TIMEOUT-1: next state HALT, error_o<=1.
  - Else: wait counter increments.
- HALT: all pipeline registers frozen (pipe_stall_o=1, PC/IF_ID write 0). Exit only via rst_i.
- Reset asserted mid-MEM_WAIT or in HALT returns to RUN on the next edge, with counters cleared.
- Perf counters:
  - stall_cnt_o increments on each cycle with PC_write_o=0.
  - flush_cnt_o increments on each cycle with IF_ID_flush_o=1.
  - Both saturate at 2^CNT_W-1 and never wrap. Counters are registered, so they reflect the previous cycle.
- Register 0 never causes a load-use stall.

Decomposition:
- Shared package holds:
  - state encoding constants RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2;
  - REG_ZERO=5'd0.
- One sub-module, sat_counter (params W; ports clk_i, rst_i, inc_i, cnt_o), instantiated twice for the perf counters.

Test Plan:
- Load into r5 in EX (MemRead=1, RT=5), ID rs=5 -> exactly one cycle of PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1; next cycle, with MemRead=0, idle values; stall_cnt_o=1.
- Load with RT=0 matching ID rs=0 -> no stall; same load with RT=5 plus branch_taken_i=1 -> bubble=1, flush=0; next cycle (hazard gone) flush=1, flush_cnt_o increments.
- dmem_req_i=1, ack low 3 cycles then high -> pipe_stall_o=1 for 3 cycles; ack cycle pipe_stall_o=0; state RUN; stall_cnt_o=3.
- dmem_req_i=1 and dmem_ack_i=1 in the same cycle -> no stall, stall_cnt_o unchanged.
- MEM_TIMEOUT=4, req held with no ack -> error_o=1 after the 4th stall cycle; outputs frozen indefinitely; rst_i=1 for one cycle -> RUN, error_o=0, counters 0.
- CNT_W=4, force 20 stall cycles -> stall_cnt_o holds at 15.
